// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: architectural widths, the x0 index and ALU opcodes,
// so decode, register file and execute agree on one encoding.
package riscv_pkg;

    localparam int         XLEN       = 32;
    localparam int         REG_ADDR_W = 5;
    localparam logic [4:0] ZERO_REG   = 5'd0;

    // {funct7[5], funct3} encoding used by the execute stage
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

endpackage

// File: rtl/reg_read_port.sv
// One combinational register-file read port: reset gate > x0 > write bypass > storage.
// Latency: zero cycles, address to data.
// Backpressure: none; the port always returns data.
module reg_read_port
    import riscv_pkg::*;
#(
    parameter int DATA_W    = XLEN,
    parameter int ADDR_W    = REG_ADDR_W,
    parameter bit BYPASS_EN = 1'b1,
    localparam int NREGS    = 2**ADDR_W
) (
    input  logic              rst_n_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [DATA_W-1:0] regs_i [NREGS],
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] rs_data_o
);

    always_comb begin
        rs_data_o = '0;
        if (!rst_n_i) begin
            rs_data_o = '0;
        end else if (rs_addr_i == '0) begin
            rs_data_o = '0;
        end else if (BYPASS_EN && wr_en_i && (wr_addr_i == rs_addr_i)) begin
            rs_data_o = wr_data_i;
        end else begin
            rs_data_o = regs_i[rs_addr_i];
        end
    end

endmodule

// File: rtl/reg_block_2r1w.sv
// RV32I integer register file, 2 combinational read ports and 1 synchronous write port.
// Latency: reads zero cycles; writes visible next cycle, or same cycle through the bypass.
// Backpressure: none; every enabled write is accepted, and writes to x0 are dropped.
module reg_block_2r1w
    import riscv_pkg::*;
#(
    parameter int DATA_W    = XLEN,
    parameter int ADDR_W    = REG_ADDR_W,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [ADDR_W-1:0] rs_1_addr_in,
    input  logic [ADDR_W-1:0] rs_2_addr_in,
    input  logic [ADDR_W-1:0] rd_addr_in,
    input  logic [DATA_W-1:0] rd_data_in,
    input  logic              wr_en_in,
    output logic [DATA_W-1:0] rs_1_out,
    output logic [DATA_W-1:0] rs_2_out
);

    localparam int                NREGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] X0    = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs_q [1:NREGS-1];
    logic [DATA_W-1:0] regs_d [1:NREGS-1];
    logic [DATA_W-1:0] rf_view [NREGS];
    logic              wr_take;

    assign wr_take = wr_en_in && (rd_addr_in != X0);

    always_comb begin
        regs_d = regs_q;
        if (wr_take) begin
            regs_d[rd_addr_in] = rd_data_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 1; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // x0 has no storage; the read ports see a constant zero at index 0
    always_comb begin
        rf_view[0] = '0;
        for (int i = 1; i < NREGS; i++) begin
            rf_view[i] = regs_q[i];
        end
    end

    reg_read_port #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BYPASS_EN (BYPASS_EN)
    ) u_rs_1 (
        .rst_n_i   (rst_n_in),
        .rs_addr_i (rs_1_addr_in),
        .regs_i    (rf_view),
        .wr_en_i   (wr_en_in),
        .wr_addr_i (rd_addr_in),
        .wr_data_i (rd_data_in),
        .rs_data_o (rs_1_out)
    );

    reg_read_port #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BYPASS_EN (BYPASS_EN)
    ) u_rs_2 (
        .rst_n_i   (rst_n_in),
        .rs_addr_i (rs_2_addr_in),
        .regs_i    (rf_view),
        .wr_en_i   (wr_en_in),
        .wr_addr_i (rd_addr_in),
        .wr_data_i (rd_data_in),
        .rs_data_o (rs_2_out)
    );

endmodule

// File: doc/reg_block_2r1w.md
Name: reg_block_2r1w

Overview:
RV32I integer register file sitting directly upstream of the execute-stage ALU; its two read ports drive the ALU operand inputs op_1_in / op_2_in.
- 32 x 32-bit architectural registers, x0 hardwired to zero.
- Two combinational read ports and one synchronous write port.
- Internal write-to-read bypass, so an instruction reading a register in the same cycle that write-back writes it sees the new value.

Parameters:
DATA_W, 32, register and port data width
ADDR_W, 5, register index width (2**ADDR_W registers)
BYPASS_EN, 1, 1 = same-cycle write-to-read forwarding enabled; 0 = read returns stored value only

Ports:
clk_in  input  1  single clock; all register updates on rising edge
rst_n_in  input  1  reset, asynchronous assert, active-low
rs_1_addr_in  input  ADDR_W  read port 1 register index
rs_2_addr_in  input  ADDR_W  read port 2 register index
rd_addr_in  input  ADDR_W  write register index
rd_data_in  input  DATA_W  write data (from write-back stage)
wr_en_in  input  1  write enable, sampled on rising clk_in
rs_1_out  output  DATA_W  read port 1 data (feeds ALU op_1_in)
rs_2_out  output  DATA_W  read port 2 data (feeds ALU op_2_in)

Behaviour:
- Interface: one clock (clk_in); reset rst_n_in is asynchronous and active-low.
- Reset:
  - rst_n_in low immediately clears x1..x31 to 0, with no clock edge required.
  - While rst_n_in is low, writes are ignored and the bypass is gated off, so rs_1_out = rs_2_out = 0.
  - Deassertion is taken synchronously by the design: the first write accepted is on the first rising edge with rst_n_in high.
- Write:
  - On rising clk_in with rst_n_in high, wr_en_in = 1 and rd_addr_in != 0: reg[rd_addr_in] <= rd_data_in.
  - rd_addr_in = 0: write discarded; x0 storage does not exist.
- Read:
  - Purely combinational, zero-cycle latency from address to data.
  - Address 0 always returns 0, regardless of a pending write to x0.
  - Otherwise returns reg[addr].
- Bypass (BYPASS_EN = 1):
  - If wr_en_in = 1, rd_addr_in != 0 and rd_addr_in == rs_N_addr_in, then rs_N_out = rd_data_in in the same cycle.
  - Applies independently per port; both ports may bypass simultaneously when both match.
  - Write-first semantics: the bypassed value equals what the register holds after the edge.
- BYPASS_EN = 0: reads see the stored value; new data is visible the cycle after the write edge.
- Read priority per port: reset gate > x0 zero > bypass > storage.
- Simultaneous events:
  - Both ports may read the same index; both receive identical data.
  - A read of index k in the same cycle as a write to index j != k is unaffected.
- Reset mid-operation: a write presented in the same cycle reset asserts is lost. Registers read 0 after reset releases.
- No X propagation: with all-valid inputs, outputs are never X.

Decomposition:
- Shared package (riscv_pkg):
  - XLEN = 32, REG_ADDR_W = 5, ZERO_REG = 5'd0.
  - ALU opcode localparams (ADD 4'b0000, SUB 4'b1000, ... SRA 4'b1101), so decode and execute share one definition.
- One natural sub-module, reg_read_port:
  - Takes the read address, the storage array view and the write-port signals.
  - Applies the reset gate, x0 and bypass priority.
  - Instantiated twice, once for rs_1 and once for rs_2.
- Storage array and write logic stay in reg_block_2r1w.

Test Plan:
- Reset: drive rst_n_in = 0 mid-cycle with x5 = 32'hDEADBEEF previously written -> rs_1_out = 0 immediately, with no clock. After release, reading x5 -> 32'h00000000.
- Basic write/read: write x7 = 32'h12345678 (wr_en_in = 1) on edge N, then set rs_1_addr_in = 7 and rs_2_addr_in = 7 -> both outputs 32'h12345678 from edge N onward.
- x0 protection: write rd_addr_in = 0, rd_data_in = 32'hFFFFFFFF, read rs_1_addr_in = 0 in the same and the next cycle -> rs_1_out = 0 both cycles; bypass not taken.
- Bypass: x3 = 32'h1. In one cycle write x3 = 32'hA5A5A5A5 with rs_1_addr_in = 3 and rs_2_addr_in = 4 (x4 = 32'h2) -> rs_1_out = 32'hA5A5A5A5 before the edge, rs_2_out = 32'h2. Repeat with BYPASS_EN = 0 -> rs_1_out = 32'h1 until the edge.
- Dual-port same index plus write-enable low: rs_1 = rs_2 = x10 = 32'h0000_0100, rd_addr_in = 10, wr_en_in = 0, rd_data_in = 32'h5 -> both outputs 32'h100, and x10 unchanged after the edge.
- Reset during write: assert rst_n_in in the cycle wr_en_in = 1 writes x9 = 32'h77 -> after release x9 = 0. Then a sweep writing xi = i for i = 1..31 reads back every value on both ports.
